// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: logical source codes, map-entry layout,
// coin stretcher states and the PS/2 set-2 scan codes recognised by the key latches.
package arcade_input_pkg;

    localparam int SRC_CONST0      = 0;
    localparam int SRC_CONST1      = 1;
    localparam int SRC_COIN1       = 2;
    localparam int SRC_COIN2       = 3;
    localparam int SRC_TEST        = 4;
    localparam int SRC_PLAYER_BASE = 8;

    localparam int CTL_UP    = 0;
    localparam int CTL_DOWN  = 1;
    localparam int CTL_LEFT  = 2;
    localparam int CTL_RIGHT = 3;
    localparam int CTL_FIRE1 = 4;
    localparam int CTL_FIRE2 = 5;
    localparam int CTL_START = 6;
    localparam int CTL_RSVD  = 7;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;
    localparam int JOY_START = 6;
    localparam int JOY_COIN  = 7;

    localparam int MAP_SRC_LSB = 0;
    localparam int MAP_SRC_MSB = 5;
    localparam int MAP_INV_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_LOCK  = 2'd2
    } coin_state_e;

    // Key latch layout: P1 controls 0..6, P2 controls 7..13, then coin1, coin2, test.
    localparam int NUM_KEYS  = 17;
    localparam int KEY_COIN1 = 14;
    localparam int KEY_COIN2 = 15;
    localparam int KEY_TEST  = 16;
    localparam logic [4:0] KEY_NONE = 5'd31;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LCTRL = 8'h14;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LALT  = 8'h11;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_T     = 8'h2C;

    function automatic logic [4:0] scan_to_key(input logic [7:0] code);
        case (code)
            SC_UP:              return 5'd0;
            SC_DOWN:            return 5'd1;
            SC_LEFT:            return 5'd2;
            SC_RIGHT:           return 5'd3;
            SC_LCTRL, SC_SPACE: return 5'd4;
            SC_LALT:            return 5'd5;
            SC_1:               return 5'd6;
            SC_R:               return 5'd7;
            SC_F:               return 5'd8;
            SC_D:               return 5'd9;
            SC_G:               return 5'd10;
            SC_A:               return 5'd11;
            SC_S:               return 5'd12;
            SC_2:               return 5'd13;
            SC_5:               return 5'(KEY_COIN1);
            SC_6:               return 5'(KEY_COIN2);
            SC_T:               return 5'(KEY_TEST);
            default:            return KEY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_stretcher.sv
// Turns a raw coin rising edge into a COIN_PULSE_CYCLES-long pulse followed by an equal lockout.
// Pulse rises one cycle after the edge; no backpressure, edges during pulse/lockout are dropped.
module coin_stretcher
    import arcade_input_pkg::*;
#(
    parameter int COIN_PULSE_CYCLES = 2048
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_pulse
);

    localparam int CNT_W = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COIN_PULSE_CYCLES - 1);

    coin_state_e      r_state;
    coin_state_e      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_raw_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_raw_q <= 1'b0;
        end else begin
            r_state <= w_next;
            r_raw_q <= i_raw;
            if (w_next != r_state || r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Only a low-to-high transition arms the pulse, so a held button cannot retrigger.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_raw && !r_raw_q) w_next = ST_PULSE;
            ST_PULSE: if (r_cnt == CNT_LAST) w_next = ST_LOCK;
            ST_LOCK:  if (r_cnt == CNT_LAST) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pulse = (r_state == ST_PULSE);
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick to arcade port mapper with per-game routing table, DIP bank and coin stretching.
// One cycle from logical control change to port_out; no backpressure. ARCADE_INPUT_AUTOFIRE_EN adds autofire.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int   NUM_PLAYERS       = 2,
    parameter int   NUM_PORTS         = 3,
    parameter int   NUM_DIP           = 8,
    parameter int   MAP_INDEX         = 3,
    parameter int   DIP_INDEX         = 254,
    parameter int   COIN_PULSE_CYCLES = 2048,
    parameter logic PORT_IDLE         = 1'b0,
    parameter int   AUTOFIRE_DIV      = 65536
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [10:0]              ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joystick,
    input  logic                     ioctl_wr,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    input  logic                     autofire_en,
    output logic [8*NUM_PORTS-1:0]   port_out,
    output logic [8*NUM_DIP-1:0]     dip_out,
    output logic [1:0]               coin_pulse
);

    localparam int MAP_N  = NUM_PORTS * 8;
    localparam int MAP_AW = $clog2(MAP_N);
    localparam int DIP_AW = (NUM_DIP > 1) ? $clog2(NUM_DIP) : 1;

    logic                r_ps2_tog;
    logic                r_ps2_armed;
    logic [NUM_KEYS-1:0] r_keys;
    logic [6:0]          r_map [MAP_N];
    logic [7:0]          r_dip [NUM_DIP];
    logic [MAP_N-1:0]    r_port;

    logic       w_ps2_event;
    logic [4:0] w_key_idx;
    logic       w_af_gate;
    logic [1:0] w_raw_coin;
    logic [1:0] w_coin_pulse;
    logic [63:0] w_src;
    logic [7:0] w_player [NUM_PLAYERS];
    logic       w_map_we;
    logic       w_dip_we;
    logic       w_map_hold;
    logic       w_unused_bits;

    // The first cycle after reset only learns the toggle phase; no key event is taken.
    assign w_ps2_event = r_ps2_armed && (ps2_key[10] != r_ps2_tog);
    assign w_key_idx   = scan_to_key(ps2_key[7:0]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ps2_tog   <= 1'b0;
            r_ps2_armed <= 1'b0;
            r_keys      <= '0;
        end else begin
            r_ps2_tog   <= ps2_key[10];
            r_ps2_armed <= 1'b1;
            if (w_ps2_event && w_key_idx != KEY_NONE) begin
                r_keys[w_key_idx] <= ps2_key[9];
            end
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    logic [AF_W-1:0] r_af_cnt;
    logic            r_af_wave;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt  <= '0;
            r_af_wave <= 1'b0;
        end else if (r_af_cnt == AF_W'(AUTOFIRE_DIV - 1)) begin
            r_af_cnt  <= '0;
            r_af_wave <= ~r_af_wave;
        end else begin
            r_af_cnt <= r_af_cnt + AF_W'(1);
        end
    end

    assign w_af_gate     = ~autofire_en | r_af_wave;
    assign w_unused_bits = ^{ioctl_dout[7], ps2_key[8], joystick};
`else
    assign w_af_gate     = 1'b1;
    assign w_unused_bits = ^{ioctl_dout[7], ps2_key[8], joystick, autofire_en} ^ (AUTOFIRE_DIV > 0);
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [6:0] w_keys;
        logic [7:0] w_joy;
        if (p < 2) begin : g_keys
            assign w_keys = r_keys[7*p +: 7];
        end else begin : g_nokeys
            assign w_keys = '0;
        end
        assign w_joy = joystick[16*p +: 8];
        assign w_player[p][CTL_UP]    = w_keys[CTL_UP]    | w_joy[JOY_UP];
        assign w_player[p][CTL_DOWN]  = w_keys[CTL_DOWN]  | w_joy[JOY_DOWN];
        assign w_player[p][CTL_LEFT]  = w_keys[CTL_LEFT]  | w_joy[JOY_LEFT];
        assign w_player[p][CTL_RIGHT] = w_keys[CTL_RIGHT] | w_joy[JOY_RIGHT];
        assign w_player[p][CTL_FIRE1] = (w_keys[CTL_FIRE1] | w_joy[JOY_FIRE1]) & w_af_gate;
        assign w_player[p][CTL_FIRE2] = w_keys[CTL_FIRE2] | w_joy[JOY_FIRE2];
        assign w_player[p][CTL_START] = w_keys[CTL_START] | w_joy[JOY_START];
        assign w_player[p][CTL_RSVD]  = 1'b0;
    end

    always_comb begin
        w_raw_coin = {r_keys[KEY_COIN2], r_keys[KEY_COIN1]};
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_raw_coin[p % 2] = w_raw_coin[p % 2] | joystick[16*p + JOY_COIN];
        end
    end

    coin_stretcher #(.COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)) u_coin1 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_raw   (w_raw_coin[0]),
        .o_pulse (w_coin_pulse[0])
    );

    coin_stretcher #(.COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)) u_coin2 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_raw   (w_raw_coin[1]),
        .o_pulse (w_coin_pulse[1])
    );

    // Codes past the last present player, and 5..7, stay at the zero default.
    always_comb begin
        w_src             = '0;
        w_src[SRC_CONST1] = 1'b1;
        w_src[SRC_COIN1]  = w_coin_pulse[0];
        w_src[SRC_COIN2]  = w_coin_pulse[1];
        w_src[SRC_TEST]   = r_keys[KEY_TEST];
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_src[SRC_PLAYER_BASE + 8*p +: 8] = w_player[p];
        end
    end

    assign w_map_we   = ioctl_wr && (ioctl_index == 8'(MAP_INDEX)) && (ioctl_addr < 25'(MAP_N));
    assign w_dip_we   = ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) && (ioctl_addr < 25'(NUM_DIP));
    assign w_map_hold = ioctl_download && (ioctl_index == 8'(MAP_INDEX));

    // Table lookup uses the pre-write entry, so a same-cycle write shows up one cycle later.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < MAP_N; j++) r_map[j] <= '0;
            for (int d = 0; d < NUM_DIP; d++) r_dip[d] <= '0;
            r_port <= '0;
        end else begin
            if (w_map_we) r_map[ioctl_addr[MAP_AW-1:0]] <= ioctl_dout[6:0];
            if (w_dip_we) r_dip[ioctl_addr[DIP_AW-1:0]] <= ioctl_dout;
            for (int j = 0; j < MAP_N; j++) begin
                r_port[j] <= w_map_hold ? PORT_IDLE
                           : (w_src[r_map[j][MAP_SRC_MSB:MAP_SRC_LSB]] ^ r_map[j][MAP_INV_BIT]);
            end
        end
    end

    always_comb begin
        for (int d = 0; d < NUM_DIP; d++) dip_out[8*d +: 8] = r_dip[d];
    end

    assign port_out   = r_port;
    assign coin_pulse = w_coin_pulse;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: vector table for the mapping path plus hand sequences
// for download hold, DIP bank, coin stretching/lockout, reset mid-pulse and (optionally) autofire.
module tb_arcade_input_mapper;

    localparam int CPC = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [31:0] joystick;
    logic        ioctl_wr;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        autofire_en;
    logic [23:0] port_out;
    logic [63:0] dip_out;
    logic [1:0]  coin_pulse;

    arcade_input_mapper #(
        .NUM_PLAYERS(2), .NUM_PORTS(3), .NUM_DIP(8), .MAP_INDEX(3), .DIP_INDEX(254),
        .COIN_PULSE_CYCLES(CPC), .PORT_IDLE(1'b0), .AUTOFIRE_DIV(4)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .autofire_en(autofire_en),
        .port_out(port_out), .dip_out(dip_out), .coin_pulse(coin_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [31:0] joy;
        bit          tog;
        logic [8:0]  code;
        bit          press;
        logic [23:0] exp;
    } vec_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
    } map_t;

    int checks   = 0;
    int failures = 0;
    bit tog      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = d;
        @(negedge clk_sys);
        ioctl_wr    = 1'b0;
    endtask

    task automatic ps2_event(input logic [8:0] code, input bit press);
        tog     = ~tog;
        ps2_key = {tog, press, code};
    endtask

    task automatic count_high(input int n, output int np, output int nc);
        np = 0;
        nc = 0;
        repeat (n) begin
            @(negedge clk_sys);
            np += int'(port_out[2]);
            nc += int'(coin_pulse[0]);
        end
    endtask

    vec_t vecs[27];
    map_t maps[14];

    initial begin
        int p0, c0, p1, c1, pt, ct;
        logic [15:0] s;

        maps = '{
            '{25'd0, 8'h0B}, '{25'd1, 8'h4B}, '{25'd2, 8'h02}, '{25'd3, 8'h01},
            '{25'd4, 8'h41}, '{25'd5, 8'h70}, '{25'd6, 8'h11}, '{25'd7, 8'h14},
            '{25'd8, 8'h0C}, '{25'd9, 8'h0F}, '{25'd10, 8'h0E}, '{25'd11, 8'h0D},
            '{25'd12, 8'h04}, '{25'd13, 8'h08}
        };
        vecs = '{
            '{32'h0000_0001, 1'b0, 9'h000, 1'b0, 24'h000029},
            '{32'h0000_0000, 1'b0, 9'h000, 1'b0, 24'h00002A},
            '{32'h0000_0000, 1'b1, 9'h029, 1'b1, 24'h00012A},
            '{32'h0000_0000, 1'b1, 9'h029, 1'b0, 24'h00002A},
            '{32'h0000_0000, 1'b0, 9'h029, 1'b1, 24'h00002A},
            '{32'h0000_0000, 1'b1, 9'h02B, 1'b1, 24'h00006A},
            '{32'h0010_0000, 1'b0, 9'h000, 1'b0, 24'h0000EA},
            '{32'h0014_0000, 1'b0, 9'h000, 1'b0, 24'h0000EA},
            '{32'h0014_0000, 1'b1, 9'h02B, 1'b0, 24'h0000EA},
            '{32'h0000_0000, 1'b0, 9'h000, 1'b0, 24'h00002A},
            '{32'h0000_0000, 1'b1, 9'h016, 1'b1, 24'h00042A},
            '{32'h0000_0000, 1'b1, 9'h011, 1'b1, 24'h000C2A},
            '{32'h0000_0000, 1'b1, 9'h02C, 1'b1, 24'h001C2A},
            '{32'h0000_0000, 1'b1, 9'h075, 1'b1, 24'h003C2A},
            '{32'h0000_0008, 1'b1, 9'h075, 1'b0, 24'h003C2A},
            '{32'h0000_0000, 1'b1, 9'h016, 1'b0, 24'h00182A},
            '{32'h0000_0000, 1'b1, 9'h174, 1'b1, 24'h001829},
            '{32'h0000_0000, 1'b1, 9'h174, 1'b0, 24'h00182A},
            '{32'h0000_0000, 1'b1, 9'h072, 1'b1, 24'h00182A},
            '{32'h0000_0000, 1'b1, 9'h011, 1'b0, 24'h00102A},
            '{32'h0000_0000, 1'b1, 9'h02C, 1'b0, 24'h00002A},
            '{32'h0000_0000, 1'b1, 9'h014, 1'b1, 24'h00012A},
            '{32'h0000_0000, 1'b1, 9'h014, 1'b0, 24'h00002A},
            '{32'h0000_0000, 1'b1, 9'h01C, 1'b1, 24'h0000AA},
            '{32'h0000_0000, 1'b1, 9'h01C, 1'b0, 24'h00002A},
            '{32'h0000_0010, 1'b0, 9'h000, 1'b0, 24'h00012A},
            '{32'h0000_0000, 1'b0, 9'h000, 1'b0, 24'h00002A}
        };

        reset_n = 1'b0; ps2_key = '0; joystick = '0; autofire_en = 1'b0;
        ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_port", 64'(port_out), 64'h0);
        check("rst_dip", dip_out, 64'h0);
        check("rst_coin", 64'(coin_pulse), 64'h0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Map download: ports held at PORT_IDLE throughout, mapping resumes right after.
        ioctl_download = 1'b1;
        ioctl_index    = 8'd3;
        @(negedge clk_sys);
        foreach (maps[i]) begin
            ioctl_write(8'd3, maps[i].addr, maps[i].data);
            check("dl_idle", 64'(port_out), 64'h0);
        end
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("dl_resume", 64'(port_out), 64'h2A);

        joystick = 32'h1;
        @(negedge clk_sys);
        check("lat_press", 64'(port_out[1:0]), 64'h1);
        joystick = 32'h0;
        @(negedge clk_sys);
        check("lat_release", 64'(port_out[1:0]), 64'h2);

        ioctl_write(8'd3, 25'd3, 8'h41);
        check("map_same_cycle_old", 64'(port_out[3]), 64'h1);
        @(negedge clk_sys);
        check("map_new", 64'(port_out[3]), 64'h0);
        ioctl_write(8'd3, 25'd3, 8'h01);
        ioctl_write(8'd3, 25'd24, 8'h41);
        ioctl_write(8'd5, 25'd0, 8'h41);
        @(negedge clk_sys);
        check("map_ignore", 64'(port_out), 64'h2A);

        foreach (vecs[i]) begin
            joystick = vecs[i].joy;
            if (vecs[i].tog) tog = ~tog;
            ps2_key = {tog, vecs[i].press, vecs[i].code};
            @(negedge clk_sys);
            @(negedge clk_sys);
            check($sformatf("vec%0d", i), 64'(port_out), 64'(vecs[i].exp));
        end

        for (int a = 0; a <= 8; a++) ioctl_write(8'd254, 25'(a), 8'hA5);
        check("dip_fill", dip_out, {8{8'hA5}});
        ioctl_write(8'd254, 25'd8, 8'h3C);
        ioctl_write(8'd254, 25'h100, 8'h3C);
        check("dip_oob", dip_out, {8{8'hA5}});
        ioctl_write(8'd254, 25'd2, 8'h5A);
        check("dip_byte2", dip_out, 64'hA5A5_A5A5_A55A_A5A5);

        // Held coin: one pulse of exactly CPC cycles.
        ps2_event(9'h02E, 1'b1);
        count_high(100, p0, c0);
        ps2_event(9'h02E, 1'b0);
        count_high(40, p1, c1);
        check("coin_hold_port", 64'(p0 + p1), 64'(CPC));
        check("coin_hold_led", 64'(c0 + c1), 64'(CPC));

        ps2_event(9'h02E, 1'b1);
        count_high(6, p0, c0);
        ps2_event(9'h02E, 1'b0);
        count_high(14, p1, c1);
        check("coin_a_port", 64'(p0 + p1), 64'(CPC));
        check("coin_a_led", 64'(c0 + c1), 64'(CPC));
        ps2_event(9'h02E, 1'b1);
        count_high(10, p0, c0);
        ps2_event(9'h02E, 1'b0);
        count_high(20, p1, c1);
        check("coin_lockout", 64'(p0 + p1 + c0 + c1), 64'h0);
        ps2_event(9'h02E, 1'b1);
        count_high(30, pt, ct);
        ps2_event(9'h02E, 1'b0);
        count_high(40, p1, c1);
        check("coin_after_lock", 64'(pt + p1), 64'(CPC));

        joystick = 32'h0000_0080;
        count_high(30, pt, ct);
        joystick = 32'h0;
        count_high(40, p1, c1);
        check("coin_joy_p1", 64'(ct + c1), 64'(CPC));

`ifdef ARCADE_INPUT_AUTOFIRE_EN
        joystick    = 32'h10;
        autofire_en = 1'b1;
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys);
            s[i] = port_out[8];
        end
        check("af_duty", 64'($countones(s)), 64'd8);
        for (int i = 4; i < 16; i++) check("af_toggle", 64'(s[i]), 64'(~s[i-4]));
        autofire_en = 1'b0;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            check("af_off_steady", 64'(port_out[8]), 64'h1);
        end
        joystick = 32'h0;
        repeat (2) @(negedge clk_sys);
`endif

        // Reset in the middle of a pulse.
        ps2_event(9'h02E, 1'b1);
        repeat (5) @(negedge clk_sys);
        check("pre_rst_led", 64'(coin_pulse[0]), 64'h1);
        check("pre_rst_port", 64'(port_out[2]), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_led", 64'(coin_pulse), 64'h0);
        check("async_rst_port", 64'(port_out), 64'h0);
        check("async_rst_dip", dip_out, 64'h0);
        tog     = 1'b1;
        ps2_key = {1'b1, 1'b1, 9'h074};
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("post_rst_dip", dip_out, 64'h0);
        check("post_rst_map", 64'(port_out), 64'h0);
        ioctl_write(8'd3, 25'd0, 8'h0B);
        @(negedge clk_sys);
        check("ps2_first_cycle", 64'(port_out), 64'h0);
        ps2_event(9'h074, 1'b1);
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("ps2_after_rst", 64'(port_out), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
